// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared types and constants for the seven-segment scroll sequencer
package sevseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_PERIOD = 4'd2;
  localparam logic [3:0] REG_LENGTH = 4'd3;
  localparam logic [3:0] REG_BUF_LO = 4'd4;
  localparam logic [3:0] REG_BUF_HI = 4'd5;
  localparam logic [3:0] REG_EXT    = 4'd6;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_DIR    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] BLANK_EN   = 8'hFF;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] wdat,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sevseg_frame_map.sv
// rtl/sevseg_frame_map.sv - maps scroll position and message buffer onto the eight digits
module sevseg_frame_map
  import sevseg_pkg::*;
(
  input  logic [4:0]  pos,
  input  logic [4:0]  len,
  input  logic        dir,
  input  logic        static_view,
  input  logic [63:0] buf_nib,
  input  logic [15:0] buf_ext,
  output logic [31:0] digits,
  output logic [7:0]  enables,
  output logic [7:0]  extended
);

  logic [2:0]        j;
  logic signed [5:0] k;
  logic [3:0]        idx;
  logic              in_range;

  always_comb begin
    digits   = '0;
    enables  = BLANK_EN;
    extended = '0;
    j        = '0;
    k        = '0;
    idx      = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      j = dir ? 3'(NUM_DIGITS - 1 - i) : 3'(i);
      // Static view shows nibble i on digit i; scrolling view trails pos by one digit.
      k = static_view ? 6'(i) : ($signed({1'b0, pos}) - 6'sd1 - $signed({3'b000, j}));
      in_range = (k >= 6'sd0) && (k < $signed({1'b0, len}));
      idx = k[3:0];
      if (static_view || in_range) begin
        digits[4*i +: 4] = buf_nib[{idx, 2'b00} +: 4];
        extended[i]      = buf_ext[idx];
      end
      enables[i] = ~in_range;
    end
  end

endmodule

// File: rtl/sevseg_scroll_ctrl.sv
// rtl/sevseg_scroll_ctrl.sv - bus-mapped message scroller driving the eight-digit display registers
module sevseg_scroll_ctrl
  import sevseg_pkg::*;
#(
  parameter int BUF_DEPTH = 16,
  parameter int PERIOD_W  = 24
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_digits,
  output logic [7:0]  o_enables,
  output logic [7:0]  o_extended,
  output logic        o_busy,
  output logic        o_done_irq
);

  state_e                state_q, state_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [4:0]            length_q, length_d;
  logic [63:0]           buf_q, buf_d;
  logic [15:0]           ext_q, ext_d;
  logic                  done_q, done_d;
  logic [4:0]            len_q, len_d;
  logic [PERIOD_W-1:0]   per_q, per_d;
  logic                  dir_q, dir_d;
  logic [4:0]            pos_q, pos_d;
  logic [PERIOD_W-1:0]   tick_q, tick_d;
  logic                  busy_q, busy_d;
  logic                  rearm_q, rearm_d;
  logic [31:0]           digits_q, digits_d;
  logic [7:0]            enables_q, enables_d;
  logic [7:0]            extended_q, extended_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdt_q, rdt_d;

  logic                  run, access, wr, step, last, show_static;
  logic [3:0]            word;
  logic [4:0]            len_clamped;
  logic [PERIOD_W-1:0]   per_eff;
  logic [31:0]           map_digits;
  logic [7:0]            map_enables, map_extended;
  logic                  unused_adr;

  assign unused_adr  = ^i_wb_adr[1:0];
  assign run         = ctrl_q[CTRL_RUN];
  assign access      = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr          = access & i_wb_we;
  assign word        = i_wb_adr[5:2];
  assign len_clamped = (length_q > 5'(BUF_DEPTH)) ? 5'(BUF_DEPTH) : length_q;
  assign per_eff     = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign step        = (tick_q == per_q - PERIOD_W'(1));
  assign last        = (pos_q == len_q + 5'd7);
  assign show_static = (state_q == ST_IDLE) && !run;

  sevseg_frame_map u_frame_map (
    .pos         (pos_q),
    .len         ((state_q == ST_RUN) ? len_q : len_clamped),
    .dir         ((state_q == ST_RUN) ? dir_q : 1'b0),
    .static_view (state_q != ST_RUN),
    .buf_nib     (buf_q),
    .buf_ext     (ext_q),
    .digits      (map_digits),
    .enables     (map_enables),
    .extended    (map_extended)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      period_q   <= '0;
      length_q   <= '0;
      buf_q      <= '0;
      ext_q      <= '0;
      done_q     <= 1'b0;
      len_q      <= '0;
      per_q      <= '0;
      dir_q      <= 1'b0;
      pos_q      <= '0;
      tick_q     <= '0;
      busy_q     <= 1'b0;
      rearm_q    <= 1'b0;
      digits_q   <= '0;
      enables_q  <= BLANK_EN;
      extended_q <= '0;
      ack_q      <= 1'b0;
      rdt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      length_q   <= length_d;
      buf_q      <= buf_d;
      ext_q      <= ext_d;
      done_q     <= done_d;
      len_q      <= len_d;
      per_q      <= per_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      rearm_q    <= rearm_d;
      digits_q   <= digits_d;
      enables_q  <= enables_d;
      extended_q <= extended_d;
      ack_q      <= ack_d;
      rdt_q      <= rdt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run && len_clamped != 5'd0 && !rearm_q) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (!run)                               state_d = ST_IDLE;
        else if (step && last && !ctrl_q[CTRL_LOOP]) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    length_d = length_q;
    buf_d    = buf_q;
    ext_d    = ext_q;
    done_d   = done_q;
    len_d    = len_q;
    per_d    = per_q;
    dir_d    = dir_q;
    pos_d    = pos_q;
    tick_d   = tick_q;
    rdt_d    = rdt_q;
    ack_d    = access;

    if (access) begin
      case (word)
        REG_CTRL:   rdt_d = {28'd0, ctrl_q};
        REG_STATUS: rdt_d = {19'd0, pos_q, 6'd0, done_q, busy_q};
        REG_PERIOD: rdt_d = 32'(period_q);
        REG_LENGTH: rdt_d = {27'd0, length_q};
        REG_BUF_LO: rdt_d = buf_q[31:0];
        REG_BUF_HI: rdt_d = buf_q[63:32];
        REG_EXT:    rdt_d = {16'd0, ext_q};
        default:    rdt_d = '0;
      endcase
    end

    if (wr) begin
      case (word)
        REG_CTRL:   ctrl_d        = 4'(apply_sel(32'(ctrl_q), i_wb_dat, i_wb_sel));
        REG_STATUS: if (i_wb_sel[0] && i_wb_dat[1]) done_d = 1'b0;
        REG_PERIOD: period_d      = PERIOD_W'(apply_sel(32'(period_q), i_wb_dat, i_wb_sel));
        REG_LENGTH: length_d      = 5'(apply_sel(32'(length_q), i_wb_dat, i_wb_sel));
        REG_BUF_LO: buf_d[31:0]   = apply_sel(buf_q[31:0], i_wb_dat, i_wb_sel);
        REG_BUF_HI: buf_d[63:32]  = apply_sel(buf_q[63:32], i_wb_dat, i_wb_sel);
        REG_EXT:    ext_d         = 16'(apply_sel(32'(ext_q), i_wb_dat, i_wb_sel));
        default:    ;
      endcase
    end

    // Completion outranks a same-cycle clear so a pass end is never lost.
    if (state_q == ST_DONE) done_d = 1'b1;

    case (state_q)
      ST_LOAD: begin
        len_d  = len_clamped;
        per_d  = per_eff;
        dir_d  = ctrl_q[CTRL_DIR];
        pos_d  = '0;
        tick_d = '0;
      end
      ST_RUN: begin
        if (step) begin
          tick_d = '0;
          pos_d  = last ? 5'd0 : pos_q + 5'd1;
        end else begin
          tick_d = tick_q + PERIOD_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN);
    rearm_d = rearm_q;
    if (state_q == ST_DONE) rearm_d = 1'b1;
    else if (!run)          rearm_d = 1'b0;
    if ((state_q == ST_RUN) || show_static) begin
      digits_d   = map_digits;
      enables_d  = map_enables;
      extended_d = map_extended;
    end else begin
      digits_d   = '0;
      enables_d  = BLANK_EN;
      extended_d = '0;
    end
  end

  assign o_wb_rdt   = rdt_q;
  assign o_wb_ack   = ack_q;
  assign o_digits   = digits_q;
  assign o_enables  = enables_q;
  assign o_extended = extended_q;
  assign o_busy     = busy_q;
  assign o_done_irq = done_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_sevseg_scroll_ctrl.sv
// tb/tb_sevseg_scroll_ctrl.sv - directed self-checking bench for the scroll sequencer
module tb_sevseg_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] rdt;
  logic        ack;
  logic [31:0] digits;
  logic [7:0]  enables, extended;
  logic        busy, irq;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  word;
    logic [31:0] wdat;
    logic [3:0]  wsel;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [7:0]  en_log [64];
  logic [31:0] dg_log [64];
  logic        bz_log [64];

  sevseg_scroll_ctrl #(.BUF_DEPTH(16), .PERIOD_W(24)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb_adr   (adr),
    .i_wb_dat   (dat),
    .i_wb_sel   (sel),
    .i_wb_we    (we),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .o_wb_rdt   (rdt),
    .o_wb_ack   (ack),
    .o_digits   (digits),
    .o_enables  (enables),
    .o_extended (extended),
    .o_busy     (busy),
    .o_done_irq (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_access(input logic [3:0] w, input logic [31:0] d, input logic [3:0] s,
                           input logic wr, output logic [31:0] rd);
    @(negedge clk);
    adr = {w, 2'b00}; dat = d; sel = s; we = wr; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("ack_high", {31'd0, ack}, 32'd1);
    rd = rdt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_low", {31'd0, ack}, 32'd0);
  endtask

  task automatic wb_write(input logic [3:0] w, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_access(w, d, 4'hF, 1'b1, unused_rd);
  endtask

  task automatic wb_read(input logic [3:0] w, output logic [31:0] d);
    wb_access(w, 32'd0, 4'hF, 1'b0, d);
  endtask

  task automatic record(input int n);
    for (int c = 0; c < n; c++) begin
      en_log[c] = enables;
      dg_log[c] = digits;
      bz_log[c] = busy;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  seq [16];
    logic [7:0]  exp_seq [11];
    int          n, cnt, first;

    vecs[0] = '{4'd2, 32'h00ABCDEF, 4'hF, 32'h00ABCDEF};
    vecs[1] = '{4'd2, 32'hFF123456, 4'hF, 32'h00123456};
    vecs[2] = '{4'd2, 32'h12345678, 4'h1, 32'h00123478};
    vecs[3] = '{4'd3, 32'h000000FF, 4'hF, 32'h0000001F};
    vecs[4] = '{4'd6, 32'hFFFF1234, 4'hF, 32'h00001234};
    vecs[5] = '{4'd5, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    vecs[6] = '{4'd5, 32'h000000AB, 4'h1, 32'hFFFFFFAB};
    vecs[7] = '{4'd7, 32'hDEADBEEF, 4'hF, 32'h00000000};
    vecs[8] = '{4'd0, 32'h0000000E, 4'hF, 32'h0000000E};
    vecs[9] = '{4'd0, 32'h00000000, 4'hF, 32'h00000000};
    exp_seq = '{8'hFF, 8'hFE, 8'hFC, 8'hF9, 8'hF3, 8'hE7, 8'hCF, 8'h9F, 8'h3F, 8'h7F, 8'hFF};

    rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 0; cyc = 0; stb = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", digits, 32'd0);
    check("rst_enables", {24'd0, enables}, 32'hFF);
    check("rst_busy_ack_irq", {29'd0, busy, ack, irq}, 32'd0);
    check("rst_rdt", rdt, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      wb_access(vecs[v].word, vecs[v].wdat, vecs[v].wsel, 1'b1, rd);
      wb_read(vecs[v].word, rd);
      check($sformatf("regvec%0d", v), rd, vecs[v].exp);
    end

    // static view
    wb_write(4'd4, 32'h87654321);
    wb_write(4'd3, 32'd8);
    check("static_digits", digits, 32'h87654321);
    check("static_en8", {24'd0, enables}, 32'h00);
    check("static_ext", {24'd0, extended}, 32'h34);
    wb_write(4'd3, 32'd3);
    check("static_en3", {24'd0, enables}, 32'hF8);
    check("static_digits3", digits, 32'h87654321);

    // single pass, scroll left
    wb_write(4'd4, 32'h00000021);
    wb_write(4'd3, 32'd2);
    wb_write(4'd2, 32'd4);
    wb_write(4'd0, 32'h1);
    record(50);
    n = 0; cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if ((c == 0 || en_log[c] != en_log[c-1]) && n < 16) begin
        seq[n] = en_log[c];
        n++;
      end
      if (en_log[c] == 8'hFC) begin
        cnt++;
        check("left_fc_digits", {24'd0, dg_log[c][7:0]}, 32'h12);
      end
    end
    check("left_seq_len", n, 11);
    for (int i = 0; i < 11; i++) check($sformatf("left_seq%0d", i), {24'd0, seq[i]}, {24'd0, exp_seq[i]});
    check("left_frame_len", cnt, 4);
    wb_read(4'd1, rd);
    check("left_status_done", rd, 32'h2);
    check("left_blank_after", {24'd0, enables}, 32'hFF);
    wb_write(4'd0, 32'h0);
    check("left_static_back", {24'd0, enables}, 32'hFC);

    // single pass, scroll right, with interrupt
    wb_write(4'd1, 32'h2);
    wb_write(4'd0, 32'hD);
    check("right_irq_idle", {31'd0, irq}, 32'd0);
    record(50);
    first = -1;
    for (int c = 0; c < 50; c++) if (first < 0 && en_log[c] != 8'hFF) first = c;
    check("right_found", {31'd0, first >= 0}, 32'd1);
    if (first >= 0) begin
      check("right_first_en", {24'd0, en_log[first]}, 32'h7F);
      check("right_first_d7", {28'd0, dg_log[first][31:28]}, 32'h1);
    end
    cnt = 0;
    while (!irq && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("right_irq_set", {31'd0, irq}, 32'd1);
    wb_write(4'd1, 32'h2);
    check("right_irq_clr", {31'd0, irq}, 32'd0);

    // looping, period 0, then abort
    wb_write(4'd0, 32'h0);
    wb_write(4'd3, 32'd1);
    wb_write(4'd2, 32'd0);
    wb_write(4'd0, 32'h3);
    record(40);
    cnt = 0;
    for (int c = 2; c < 38; c++) if (en_log[c] == 8'hFF) cnt++;
    check("loop_blank_count", cnt, 4);
    check("loop_pos1", {24'd0, en_log[3]}, 32'hFE);
    check("loop_pos8", {24'd0, en_log[10]}, 32'h7F);
    check("loop_busy", {31'd0, busy}, 32'd1);
    wb_write(4'd0, 32'h2);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("abort_static", {24'd0, enables}, 32'hFE);
    wb_read(4'd1, rd);
    check("abort_no_done", {30'd0, rd[1:0]}, 32'd0);

    // LENGTH above 16 clamps
    wb_write(4'd0, 32'h0);
    wb_write(4'd3, 32'd31);
    wb_write(4'd2, 32'd1);
    check("clamp_static_en", {24'd0, enables}, 32'h00);
    wb_write(4'd0, 32'h1);
    record(60);
    cnt = 0;
    for (int c = 0; c < 60; c++) if (bz_log[c]) cnt++;
    check("clamp_busy_cycles", cnt, 25);
    wb_read(4'd1, rd);
    check("clamp_done", rd, 32'h2);

    // asynchronous reset mid-scroll
    wb_write(4'd0, 32'h0);
    wb_write(4'd1, 32'h2);
    wb_write(4'd4, 32'h87654321);
    wb_write(4'd3, 32'd8);
    wb_write(4'd2, 32'd4);
    wb_write(4'd0, 32'h1);
    repeat (23) @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_digits", digits, 32'd0);
    check("mid_rst_enables", {24'd0, enables}, 32'hFF);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wb_read(4'd0, rd);
    check("post_rst_ctrl", rd, 32'd0);
    wb_read(4'd1, rd);
    check("post_rst_status", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
